// File: rtl/vx_stream_route_pkg.sv
// vx_stream_route_pkg: shared stall FSM states, default sizes and a select-width helper
package vx_stream_route_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ALARM} stall_state_e;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_STALL_LIMIT = 64;
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vx_route_fifo.sv
// vx_route_fifo: per-lane FIFO holding {sel,data}; a full FIFO rejects a push even when popping
module vx_route_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vx_route_fifo: DEPTH must be a power of 2 and >= 2");
  end
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign dout = mem_q[rd_q];
  assign wr_d = do_push ? wr_q + PW'(1) : wr_q;
  assign rd_d = do_pop ? rd_q + PW'(1) : rd_q;
  assign cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/vx_stream_route_queue.sv
// vx_stream_route_queue: lane FIFOs with enqueue-time output select, head-of-line stall alarm and stall perf counter (VX_STREAM_ROUTE_HASH_EN folds upper address bits into sel)
module vx_stream_route_queue
  import vx_stream_route_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int DATAW = 32,
  parameter int ADDRW = 32,
  parameter int ADDR_LSB = 2,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int STALL_LIMIT = DEFAULT_STALL_LIMIT,
  parameter int PERF_CTR_BITS = 32,
  parameter int OUT_WIDTH = log2up(NUM_OUTPUTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_INPUTS-1:0]           valid_in,
  input  logic [NUM_INPUTS*DATAW-1:0]     data_in,
  input  logic [NUM_INPUTS*ADDRW-1:0]     addr_in,
  output logic [NUM_INPUTS-1:0]           ready_in,
  output logic [NUM_INPUTS-1:0]           valid_out,
  output logic [NUM_INPUTS*DATAW-1:0]     data_out,
  output logic [NUM_INPUTS*OUT_WIDTH-1:0] sel_out,
  input  logic [NUM_INPUTS-1:0]           ready_out,
  output logic [NUM_INPUTS-1:0]           stall_alarm,
  output logic [PERF_CTR_BITS-1:0]        stall_cycles
);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  if (NUM_OUTPUTS < 1 || (NUM_OUTPUTS & (NUM_OUTPUTS - 1)) != 0) begin : g_bad_outputs
    $error("vx_stream_route_queue: NUM_OUTPUTS must be a power of 2");
  end
  if (STALL_LIMIT < 1) begin : g_bad_limit
    $error("vx_stream_route_queue: STALL_LIMIT must be >= 1");
  end
`ifdef VX_STREAM_ROUTE_HASH_EN
  if (ADDR_LSB + 2 * OUT_WIDTH > ADDRW) begin : g_bad_hash
    $error("vx_stream_route_queue: hashed select exceeds ADDRW");
  end
`endif
  logic [NUM_INPUTS-1:0] blocked;
  logic [PERF_CTR_BITS-1:0] blocked_cnt, stall_cycles_q;
  logic unused_addr;
  assign unused_addr = ^addr_in;
  assign blocked = valid_out & ~ready_out;
  assign stall_cycles = stall_cycles_q;
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    logic [OUT_WIDTH-1:0] sel;
    logic full, empty;
    stall_state_e state_q, state_d;
    logic [SW-1:0] ctr_q, ctr_d;
`ifdef VX_STREAM_ROUTE_HASH_EN
    assign sel = (NUM_OUTPUTS == 1) ? '0 :
                 addr_in[i*ADDRW+ADDR_LSB +: OUT_WIDTH] ^ addr_in[i*ADDRW+ADDR_LSB+OUT_WIDTH +: OUT_WIDTH];
`else
    assign sel = (NUM_OUTPUTS == 1) ? '0 : addr_in[i*ADDRW+ADDR_LSB +: OUT_WIDTH];
`endif
    vx_route_fifo #(.DEPTH(DEPTH), .W(OUT_WIDTH + DATAW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (valid_in[i] & ready_in[i]),
      .pop   (valid_out[i] & ready_out[i]),
      .din   ({sel, data_in[i*DATAW +: DATAW]}),
      .dout  ({sel_out[i*OUT_WIDTH +: OUT_WIDTH], data_out[i*DATAW +: DATAW]}),
      .full  (full),
      .empty (empty)
    );
    assign ready_in[i] = !full;
    assign valid_out[i] = !empty;
    assign stall_alarm[i] = state_q == ALARM;
    // stall state and saturating blocked-run counter
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        ctr_q <= '0;
      end else begin
        state_q <= state_d;
        ctr_q <= ctr_d;
      end
    end
    // any unblocked cycle clears the run; reaching the limit raises the alarm
    always_comb begin
      state_d = state_q;
      ctr_d = ctr_q;
      if (!blocked[i]) begin
        state_d = IDLE;
        ctr_d = '0;
      end else if (state_q == IDLE) begin
        ctr_d = SW'(1);
        state_d = (ctr_d == SW'(STALL_LIMIT)) ? ALARM : WAIT;
      end else if (state_q == WAIT) begin
        ctr_d = ctr_q + SW'(1);
        state_d = (ctr_d == SW'(STALL_LIMIT)) ? ALARM : WAIT;
      end
    end
  end
  // number of lanes blocked this cycle
  always_comb begin
    blocked_cnt = '0;
    for (int j = 0; j < NUM_INPUTS; j++) blocked_cnt = blocked_cnt + PERF_CTR_BITS'(blocked[j]);
  end
  // wrapping blocked lane-cycle accumulator
  always_ff @(posedge clk) begin
    if (reset) stall_cycles_q <= '0;
    else stall_cycles_q <= stall_cycles_q + blocked_cnt;
  end
endmodule

// File: tb/tb_vx_stream_route_queue.sv
// tb_vx_stream_route_queue: directed scenarios plus randomized traffic against a queue-based model
module tb_vx_stream_route_queue;
  localparam int NI = 4, DW = 32, AW = 32, OW = 2, D = 4, SL = 64, PB = 32;
  logic clk = 0, reset;
  logic [NI-1:0] valid_in, ready_in, valid_out, ready_out, stall_alarm;
  logic [NI*DW-1:0] data_in, data_out;
  logic [NI*AW-1:0] addr_in;
  logic [NI*OW-1:0] sel_out;
  logic [PB-1:0] stall_cycles;
  int checks = 0, failures = 0;
  logic [OW+DW-1:0] mq [NI][$];
  int run [NI];
  logic [PB-1:0] mstall;

  always #5 clk = ~clk;

  vx_stream_route_queue dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .addr_in(addr_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out), .sel_out(sel_out),
    .ready_out(ready_out), .stall_alarm(stall_alarm), .stall_cycles(stall_cycles)
  );

  function automatic logic [OW-1:0] msel(input logic [AW-1:0] a);
`ifdef VX_STREAM_ROUTE_HASH_EN
    return OW'((a >> 2) & 3) ^ OW'((a >> 4) & 3);
`else
    return OW'((a >> 2) & 3);
`endif
  endfunction

  task automatic drive(input int l, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    valid_in[l] = v;
    addr_in[l*AW +: AW] = a;
    data_in[l*DW +: DW] = d;
  endtask

  task automatic tick();
    for (int l = 0; l < NI; l++) begin
      automatic int n = mq[l].size();
      automatic bit b = n > 0 && !ready_out[l];
      mstall += PB'(b);
      run[l] = b ? run[l] + 1 : 0;
      if (n > 0 && ready_out[l]) void'(mq[l].pop_front());
      if (valid_in[l] && n < D) mq[l].push_back({msel(addr_in[l*AW +: AW]), data_in[l*DW +: DW]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    valid_in = '0;
    ready_out = '1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    for (int l = 0; l < NI; l++) begin
      mq[l].delete();
      run[l] = 0;
    end
    mstall = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_out !== 4'h0) begin failures++; $display("FAIL reset_valid_out got=%h exp=0", valid_out); end
    checks++; if (ready_in !== 4'hF) begin failures++; $display("FAIL reset_ready_in got=%h exp=f", ready_in); end
    checks++; if (stall_alarm !== 4'h0) begin failures++; $display("FAIL reset_alarm got=%h exp=0", stall_alarm); end
    checks++; if (stall_cycles !== '0) begin failures++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_basic();
    do_reset();
    drive(0, 1, 32'h0000000C, 32'hA5A5_0001);
    checks++; if (valid_out[0] !== 1'b0) begin failures++; $display("FAIL basic_no_bypass got=%b exp=0", valid_out[0]); end
    tick();
    valid_in = '0;
    checks++; if (valid_out[0] !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", valid_out[0]); end
    checks++; if (sel_out[1:0] !== 2'd3) begin failures++; $display("FAIL basic_sel got=%0d exp=3", sel_out[1:0]); end
    checks++; if (data_out[31:0] !== 32'hA5A5_0001) begin failures++; $display("FAIL basic_data got=%h exp=a5a50001", data_out[31:0]); end
    tick();
    checks++; if (valid_out[0] !== 1'b0) begin failures++; $display("FAIL basic_drained got=%b exp=0", valid_out[0]); end
  endtask

  task automatic test_hash_sel();
    logic [OW-1:0] exp_sel;
`ifdef VX_STREAM_ROUTE_HASH_EN
    exp_sel = 2'd2;
`else
    exp_sel = 2'd3;
`endif
    do_reset();
    drive(0, 1, 32'h0000001C, 32'h1C);
    tick();
    valid_in = '0;
    checks++; if (sel_out[1:0] !== exp_sel) begin failures++; $display("FAIL hash_sel got=%0d exp=%0d", sel_out[1:0], exp_sel); end
    tick();
  endtask

  task automatic test_full();
    do_reset();
    ready_out = '0;
    for (int k = 1; k <= 5; k++) begin
      drive(1, 1, AW'(k << 2), DW'(k));
      tick();
      checks++; if (ready_in[1] !== (k < 4)) begin failures++; $display("FAIL full_ready_in push%0d got=%b exp=%b", k, ready_in[1], k < 4); end
    end
    valid_in = '0;
    ready_out = '1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (valid_out[1] !== 1'b1 || data_out[DW +: DW] !== DW'(k)) begin failures++; $display("FAIL full_order pos%0d got=%b/%0d exp=1/%0d", k, valid_out[1], data_out[DW +: DW], k); end
      tick();
    end
    checks++; if (valid_out[1] !== 1'b0) begin failures++; $display("FAIL full_fifth_dropped got=%b exp=0", valid_out[1]); end
  endtask

  task automatic test_alarm();
    do_reset();
    ready_out = 4'hB;
    drive(2, 1, 32'h8, 32'h22);
    tick();
    valid_in = '0;
    for (int c = 1; c <= SL; c++) begin
      tick();
      checks++; if (stall_alarm[2] !== (c >= SL)) begin failures++; $display("FAIL alarm_cycle%0d got=%b exp=%b", c, stall_alarm[2], c >= SL); end
    end
    checks++; if (stall_cycles !== PB'(64)) begin failures++; $display("FAIL alarm_stall_cycles got=%0d exp=64", stall_cycles); end
    ready_out = '1;
    tick();
    checks++; if (stall_alarm[2] !== 1'b0) begin failures++; $display("FAIL alarm_clear got=%b exp=0", stall_alarm[2]); end
    checks++; if (stall_cycles !== PB'(64)) begin failures++; $display("FAIL alarm_stall_hold got=%0d exp=64", stall_cycles); end
  endtask

  task automatic test_full_pop();
    do_reset();
    ready_out = '0;
    for (int k = 1; k <= 4; k++) begin
      drive(3, 1, 32'h0, DW'(k));
      tick();
    end
    checks++; if (ready_in[3] !== 1'b0) begin failures++; $display("FAIL fullpop_full got=%b exp=0", ready_in[3]); end
    ready_out[3] = 1;
    drive(3, 1, 32'h0, 32'd99);
    tick();
    checks++; if (ready_in[3] !== 1'b1 || data_out[3*DW +: DW] !== 32'd2) begin failures++; $display("FAIL fullpop_rejected got=%b/%0d exp=1/2", ready_in[3], data_out[3*DW +: DW]); end
    ready_out[3] = 0;
    tick();
    valid_in = '0;
    checks++; if (ready_in[3] !== 1'b0) begin failures++; $display("FAIL fullpop_accepted got=%b exp=0", ready_in[3]); end
    ready_out = '1;
    for (int k = 0; k < 4; k++) begin
      automatic logic [DW-1:0] e = (k == 3) ? 32'd99 : DW'(k + 2);
      checks++; if (data_out[3*DW +: DW] !== e) begin failures++; $display("FAIL fullpop_order pos%0d got=%0d exp=%0d", k, data_out[3*DW +: DW], e); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_out = '0;
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1, 32'h4, DW'(k));
      tick();
    end
    checks++; if (stall_cycles !== PB'(2)) begin failures++; $display("FAIL midreset_pre_stall got=%0d exp=2", stall_cycles); end
    do_reset();
    checks++; if (valid_out !== 4'h0) begin failures++; $display("FAIL midreset_valid got=%h exp=0", valid_out); end
    checks++; if (ready_in !== 4'hF) begin failures++; $display("FAIL midreset_ready got=%h exp=f", ready_in); end
    checks++; if (stall_cycles !== '0) begin failures++; $display("FAIL midreset_stall got=%0d exp=0", stall_cycles); end
    tick();
    checks++; if (valid_out !== 4'h0) begin failures++; $display("FAIL midreset_no_emit got=%h exp=0", valid_out); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      automatic int bias = (c / 100) % 3;
      for (int l = 0; l < NI; l++) begin
        drive(l, 1'($urandom_range(0, 1)), $urandom, $urandom);
        ready_out[l] = (bias == 2) ? 1'b0 : ($urandom_range(0, 3) > bias);
      end
      tick();
      for (int l = 0; l < NI; l++) begin
        automatic int n = mq[l].size();
        checks++; if (valid_out[l] !== (n > 0)) begin failures++; $display("FAIL rand_valid c%0d lane%0d got=%b exp=%b", c, l, valid_out[l], n > 0); end
        checks++; if (ready_in[l] !== (n < D)) begin failures++; $display("FAIL rand_ready c%0d lane%0d got=%b exp=%b", c, l, ready_in[l], n < D); end
        checks++; if (stall_alarm[l] !== (run[l] >= SL)) begin failures++; $display("FAIL rand_alarm c%0d lane%0d got=%b exp=%b", c, l, stall_alarm[l], run[l] >= SL); end
        if (n > 0) begin
          checks++; if ({sel_out[l*OW +: OW], data_out[l*DW +: DW]} !== mq[l][0]) begin failures++; $display("FAIL rand_head c%0d lane%0d got=%h exp=%h", c, l, {sel_out[l*OW +: OW], data_out[l*DW +: DW]}, mq[l][0]); end
        end
      end
      checks++; if (stall_cycles !== mstall) begin failures++; $display("FAIL rand_stall_cycles c%0d got=%0d exp=%0d", c, stall_cycles, mstall); end
    end
  endtask

  initial begin
    valid_in = '0;
    ready_out = '1;
    data_in = '0;
    addr_in = '0;
    mstall = '0;
    test_reset();
    test_basic();
    test_hash_sel();
    test_full();
    test_alarm();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
